// File: rtl/fetch_group_gen.sv
// fetch_group_gen: 3-wide fetch front end with predecode, taken truncation and a one-group hold register.
// Optional macro FETCH_STATIC_PREDICT_EN: predict backward B-type branches taken.
module fetch_group_gen #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i_0,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i_1,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i_2,
  input  logic                  fetch_ready_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [2:0]            fetch_valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o_0,
  output logic [DATA_WIDTH-1:0] instruction_o_1,
  output logic [DATA_WIDTH-1:0] instruction_o_2,
  output logic [DATA_WIDTH-1:0] pc_o_0,
  output logic [DATA_WIDTH-1:0] pc_o_1,
  output logic [DATA_WIDTH-1:0] pc_o_2,
  output logic [DATA_WIDTH-1:0] imm_o_0,
  output logic [DATA_WIDTH-1:0] imm_o_1,
  output logic [DATA_WIDTH-1:0] imm_o_2,
  output logic [DATA_WIDTH-1:0] pc_at_prediction_o_0,
  output logic [DATA_WIDTH-1:0] pc_at_prediction_o_1,
  output logic [DATA_WIDTH-1:0] pc_at_prediction_o_2,
  output logic                  branch_prediction_o_0,
  output logic                  branch_prediction_o_1,
  output logic                  branch_prediction_o_2
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] r_pc, r_f2_pc, r_hold_pc;
  logic         r_f2_valid, r_hold_valid;
  logic [W-1:0] r_hold_w [3];
  logic [W-1:0] w_raw [3];
  logic [W-1:0] w_ins [3];
  logic [W-1:0] w_pc  [3];
  logic [W-1:0] w_imm [3];
  logic [W-1:0] w_pat [3];
  logic [W-1:0] w_tgt [3];
  logic [2:0]   w_taken, w_valid, w_pred;
  logic [W-1:0] w_src_pc, w_target;
  logic         w_src_valid, w_req, w_taken_live, w_capture;
  // The hold register keeps raw words and base PC; predecode is shared by both sources.
  assign w_raw[0]    = r_hold_valid ? r_hold_w[0] : imem_rdata_i_0;
  assign w_raw[1]    = r_hold_valid ? r_hold_w[1] : imem_rdata_i_1;
  assign w_raw[2]    = r_hold_valid ? r_hold_w[2] : imem_rdata_i_2;
  assign w_src_pc    = r_hold_valid ? r_hold_pc : r_f2_pc;
  assign w_src_valid = r_hold_valid | r_f2_valid;
  for (genvar i = 0; i < 3; i++) begin : g_slot
    logic [W-1:0] w_word, w_pci, w_immi, w_imm_j, w_imm_b;
    logic         w_jal, w_br, w_pb;
    assign w_word  = w_raw[i];
    assign w_pci   = w_src_pc + W'(i * 4);
    assign w_jal   = w_word[6:0] == 7'b1101111;
    assign w_br    = w_word[6:0] == 7'b1100011;
    assign w_imm_j = {{(W-20){w_word[31]}}, w_word[19:12], w_word[20], w_word[30:21], 1'b0};
    assign w_imm_b = {{(W-12){w_word[31]}}, w_word[7], w_word[30:25], w_word[11:8], 1'b0};
    assign w_immi  = w_jal ? w_imm_j : w_br ? w_imm_b : '0;
`ifdef FETCH_STATIC_PREDICT_EN
    assign w_pb    = w_br & w_word[31];
`else
    assign w_pb    = 1'b0;
`endif
    assign w_taken[i] = w_jal | w_pb;
    assign w_tgt[i]   = w_pci + w_immi;
    assign w_ins[i]   = w_valid[i] ? w_word : W'(32'h13);
    assign w_pc[i]    = w_valid[i] ? w_pci : '0;
    assign w_imm[i]   = w_valid[i] ? w_immi : '0;
    assign w_pat[i]   = w_valid[i] ? (w_taken[i] ? w_tgt[i] : w_pci + W'(4)) : '0;
    assign w_pred[i]  = w_valid[i] & w_taken[i];
  end
  assign w_valid      = !w_src_valid ? 3'b000 : w_taken[0] ? 3'b001 : w_taken[1] ? 3'b011 : 3'b111;
  assign w_target     = w_taken[0] ? w_tgt[0] : w_taken[1] ? w_tgt[1] : w_tgt[2];
  assign w_taken_live = r_f2_valid & ~r_hold_valid & |w_taken;
  // A draining hold (hold_valid with ready) still allows a request, so only ready/flush/reset gate it.
  assign w_req        = fetch_ready_i & ~flush_i & ~reset;
  assign w_capture    = r_f2_valid & ~r_hold_valid & ~fetch_ready_i & ~flush_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_f2_valid   <= 1'b0;
      r_hold_valid <= 1'b0;
    end else begin
      r_pc         <= flush_i ? (redirect_pc_i & ~W'(3)) : w_taken_live ? w_target : w_req ? r_pc + W'(12) : r_pc;
      r_f2_valid   <= w_req & ~w_taken_live;
      r_hold_valid <= ~flush_i & ~fetch_ready_i & w_src_valid;
      if (w_req) r_f2_pc <= r_pc;
      if (w_capture) begin
        r_hold_pc   <= r_f2_pc;
        r_hold_w[0] <= imem_rdata_i_0;
        r_hold_w[1] <= imem_rdata_i_1;
        r_hold_w[2] <= imem_rdata_i_2;
      end
    end
  end
  assign imem_req_o            = w_req;
  assign imem_addr_o           = r_pc;
  assign fetch_valid_o         = w_valid;
  assign instruction_o_0       = w_ins[0];
  assign instruction_o_1       = w_ins[1];
  assign instruction_o_2       = w_ins[2];
  assign pc_o_0                = w_pc[0];
  assign pc_o_1                = w_pc[1];
  assign pc_o_2                = w_pc[2];
  assign imm_o_0               = w_imm[0];
  assign imm_o_1               = w_imm[1];
  assign imm_o_2               = w_imm[2];
  assign pc_at_prediction_o_0  = w_pat[0];
  assign pc_at_prediction_o_1  = w_pat[1];
  assign pc_at_prediction_o_2  = w_pat[2];
  assign branch_prediction_o_0 = w_pred[0];
  assign branch_prediction_o_1 = w_pred[1];
  assign branch_prediction_o_2 = w_pred[2];
endmodule

// File: tb/tb_fetch_group_gen.sv
// tb_fetch_group_gen: directed scenarios plus randomized traffic checked against a program-order stream model.
module tb_fetch_group_gen;
  logic        clk = 1'b0;
  logic        reset, fetch_ready_i, flush_i, imem_req_o;
  logic [31:0] redirect_pc_i, imem_addr_o;
  logic [31:0] imem_rdata_i_0, imem_rdata_i_1, imem_rdata_i_2;
  logic [2:0]  fetch_valid_o;
  logic [31:0] instruction_o_0, instruction_o_1, instruction_o_2;
  logic [31:0] pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2;
  logic [31:0] pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2;
  logic        branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
  always #5 clk = ~clk;

  fetch_group_gen #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i_0(imem_rdata_i_0), .imem_rdata_i_1(imem_rdata_i_1), .imem_rdata_i_2(imem_rdata_i_2),
    .fetch_ready_i(fetch_ready_i), .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
    .fetch_valid_o(fetch_valid_o),
    .instruction_o_0(instruction_o_0), .instruction_o_1(instruction_o_1), .instruction_o_2(instruction_o_2),
    .pc_o_0(pc_o_0), .pc_o_1(pc_o_1), .pc_o_2(pc_o_2),
    .imm_o_0(imm_o_0), .imm_o_1(imm_o_1), .imm_o_2(imm_o_2),
    .pc_at_prediction_o_0(pc_at_prediction_o_0), .pc_at_prediction_o_1(pc_at_prediction_o_1),
    .pc_at_prediction_o_2(pc_at_prediction_o_2),
    .branch_prediction_o_0(branch_prediction_o_0), .branch_prediction_o_1(branch_prediction_o_1),
    .branch_prediction_o_2(branch_prediction_o_2)
  );

  logic [31:0] mem [256];
  int          n_tests = 0, n_fail = 0, idle_cnt = 0;
  logic [31:0] exp_pc = 32'h0, pend_addr = 32'h0;
  logic        pend_req = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_flush = 1'b0, p_rst = 1'b1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] w);
    if (w[6:0] == 7'h6F) return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    if (w[6:0] == 7'h63) return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    return 32'h0;
  endfunction

  function automatic logic taken_of(input logic [31:0] w);
`ifdef FETCH_STATIC_PREDICT_EN
    return (w[6:0] == 7'h6F) || (w[6:0] == 7'h63 && $signed(imm_of(w)) < 0);
`else
    return w[6:0] == 7'h6F;
`endif
  endfunction

  // Expected slot record {pred, instr, pc, imm, predicted next pc}; invalid slots carry the idle values.
  function automatic logic [159:0] slot_exp(input logic [31:0] base, input int i, input logic v);
    logic [31:0] pc, w, imm;
    logic        t;
    pc  = base + 32'(i * 4);
    w   = rd(pc);
    t   = taken_of(w);
    imm = imm_of(w);
    return v ? {31'b0, t, w, pc, imm, t ? pc + imm : pc + 32'd4} : {31'b0, 1'b0, 32'h13, 96'b0};
  endfunction

  task automatic model();
    logic [159:0] obs [3];
    logic [159:0] e;
    logic [2:0]   efv;
    logic         v;
    obs[0] = {31'b0, branch_prediction_o_0, instruction_o_0, pc_o_0, imm_o_0, pc_at_prediction_o_0};
    obs[1] = {31'b0, branch_prediction_o_1, instruction_o_1, pc_o_1, imm_o_1, pc_at_prediction_o_1};
    obs[2] = {31'b0, branch_prediction_o_2, instruction_o_2, pc_o_2, imm_o_2, pc_at_prediction_o_2};
    if (reset) begin
      chk("req_in_reset", imem_req_o, 0);
      exp_pc   = 32'h0;
      idle_cnt = 0;
    end else begin
      chk("req", imem_req_o, fetch_ready_i & ~flush_i);
      if (p_rst) chk("post_reset_valid", fetch_valid_o, 0);
      if (flush_i) begin
        exp_pc   = redirect_pc_i & ~32'd3;
        idle_cnt = 0;
      end else begin
        if (p_valid && !p_ready && !p_flush && !p_rst) chk("stall_keep", fetch_valid_o != 0, 1);
        if (fetch_valid_o == 0 && p_ready && !p_flush && !p_rst) idle_cnt++;
        else if (fetch_valid_o != 0) idle_cnt = 0;
        chk("idle_budget", idle_cnt >= 2, 0);
        if (idle_cnt >= 2) idle_cnt = 0;
        if (fetch_valid_o == 0) begin
          for (int i = 0; i < 3; i++) chk("idle_slot", obs[i], slot_exp(0, i, 0));
        end else begin
          v = 1'b1;
          for (int i = 0; i < 3; i++) begin
            efv[i] = v;
            if (taken_of(rd(exp_pc + 32'(i * 4)))) v = 1'b0;
          end
          chk("fetch_valid", fetch_valid_o, efv);
          for (int i = 0; i < 3; i++) begin
            e = slot_exp(exp_pc, i, efv[i]);
            chk($sformatf("slot%0d", i), obs[i], e);
          end
          if (fetch_ready_i) begin
            e = slot_exp(exp_pc, efv[2] ? 2 : efv[1] ? 1 : 0, 1'b1);
            exp_pc = e[31:0];
          end
        end
      end
    end
    pend_req  = imem_req_o;
    pend_addr = imem_addr_o;
    p_valid   = fetch_valid_o != 0;
    p_ready   = fetch_ready_i;
    p_flush   = flush_i;
    p_rst     = reset;
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic fl, input logic [31:0] rp);
    @(negedge clk);
    reset          = r;
    fetch_ready_i  = rdy;
    flush_i        = fl;
    redirect_pc_i  = rp;
    imem_rdata_i_0 = pend_req ? rd(pend_addr) : $urandom();
    imem_rdata_i_1 = pend_req ? rd(pend_addr + 32'd4) : $urandom();
    imem_rdata_i_2 = pend_req ? rd(pend_addr + 32'd8) : $urandom();
    #1;
    model();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    int          r;
    reset = 1'b1; fetch_ready_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    imem_rdata_i_0 = 32'h0; imem_rdata_i_1 = 32'h0; imem_rdata_i_2 = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h13;
    // Reset and first sequential groups
    do_reset();
    cyc(0, 1, 0, 0);
    chk("t1_req", imem_req_o, 1); chk("t1_addr0", imem_addr_o, 32'h0); chk("t1_fv0", fetch_valid_o, 0);
    cyc(0, 1, 0, 0);
    chk("t1_addr1", imem_addr_o, 32'hC); chk("t1_fv1", fetch_valid_o, 3'b111);
    chk("t1_pc0", pc_o_0, 32'h0); chk("t1_pc1", pc_o_1, 32'h4); chk("t1_pc2", pc_o_2, 32'h8);
    // JAL +0x100 in slot 1
    mem[1] = 32'h1000006F;
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t2_fv", fetch_valid_o, 3'b011); chk("t2_pred1", branch_prediction_o_1, 1);
    chk("t2_pat1", pc_at_prediction_o_1, 32'h104); chk("t2_imm1", imm_o_1, 32'h100);
    cyc(0, 1, 0, 0);
    chk("t2_bubble", fetch_valid_o, 0); chk("t2_addr", imem_addr_o, 32'h104);
    cyc(0, 1, 0, 0);
    chk("t2_fv_tgt", fetch_valid_o, 3'b111); chk("t2_pc_tgt", pc_o_0, 32'h104);
    mem[1] = 32'h13;
    // Backpressure for three cycles
    do_reset();
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      chk("t3_fv", fetch_valid_o, 3'b111); chk("t3_pc0", pc_o_0, 32'h0); chk("t3_req", imem_req_o, 0);
    end
    cyc(0, 1, 0, 0);
    chk("t3_drain_fv", fetch_valid_o, 3'b111); chk("t3_drain_req", imem_req_o, 1);
    chk("t3_drain_addr", imem_addr_o, 32'hC);
    cyc(0, 1, 0, 0);
    chk("t3_next_pc", pc_o_0, 32'hC);
    // Flush during a hold
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h2000);
    cyc(0, 1, 0, 0);
    chk("t4_addr", imem_addr_o, 32'h2000); chk("t4_req", imem_req_o, 1); chk("t4_fv", fetch_valid_o, 0);
    cyc(0, 1, 0, 0);
    chk("t4_fv2", fetch_valid_o, 3'b111); chk("t4_pc0", pc_o_0, 32'h2000);
    // Misaligned redirect
    cyc(0, 1, 1, 32'h3003);
    cyc(0, 1, 0, 0);
    chk("mis_addr", imem_addr_o, 32'h3000);
    cyc(0, 1, 0, 0);
    chk("mis_pc0", pc_o_0, 32'h3000);
    // BEQ -8 at 0x40
    mem[16] = 32'hFE000CE3;
    cyc(0, 1, 1, 32'h40);
    cyc(0, 1, 0, 0);
    chk("t5_addr", imem_addr_o, 32'h40);
    cyc(0, 1, 0, 0);
    chk("t5_imm0", imm_o_0, 32'hFFFFFFF8);
`ifdef FETCH_STATIC_PREDICT_EN
    chk("t5_fv", fetch_valid_o, 3'b001); chk("t5_pat0", pc_at_prediction_o_0, 32'h38);
    cyc(0, 1, 0, 0);
    chk("t5_bubble", fetch_valid_o, 0); chk("t5_next_addr", imem_addr_o, 32'h38);
`else
    chk("t5_fv", fetch_valid_o, 3'b111); chk("t5_pat0", pc_at_prediction_o_0, 32'h44);
    cyc(0, 1, 0, 0);
    chk("t5_next_fv", fetch_valid_o, 3'b111); chk("t5_next_pc", pc_o_0, 32'h4C);
`endif
    mem[16] = 32'h13;
    // Address wrap
    cyc(0, 1, 1, 32'hFFFFFFF4);
    cyc(0, 1, 0, 0);
    chk("t6_addr", imem_addr_o, 32'hFFFFFFF4);
    cyc(0, 1, 0, 0);
    chk("t6_wrap", imem_addr_o, 32'h0);
    chk("t6_pc1", pc_o_1, 32'hFFFFFFF8); chk("t6_pc2", pc_o_2, 32'hFFFFFFFC);
    // Random program with jumps, branches, stalls, flushes and resets
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom();
      mem[i] = r < 5 ? {w[31:7], 7'h13} : r < 7 ? {w[31:22], 1'b0, w[20:7], 7'h6F} :
               r < 9 ? {w[31:9], 1'b0, w[7], 7'h63} : {w[31:7], 7'h33};
    end
    do_reset();
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
